note_sequencer_mc: RTL and testbench

//  Multi-channel successor to the single-voice note sequencer. NUM_CHANNELS pattern

---
 rtl/note_sequencer_mc.sv | 157 +++++++++++++++
 tb/tb_note_sequencer_mc.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_mc.sv
// note_sequencer_mc: NUM_CHANNELS pattern players sharing one synchronous ROM through a round-robin fetch FSM
module note_sequencer_mc #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int LEN_WIDTH    = 5,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_CHANNELS-1:0]            i_note_stb,
  input  logic                               i_new_addr_valid,
  input  logic [CH_W-1:0]                    i_new_chan,
  input  logic [ADDR_WIDTH-1:0]              i_new_addr,
  input  logic [LEN_WIDTH-1:0]               i_new_pattern_len,
  input  logic                               i_new_loop,
  output logic [ADDR_WIDTH-1:0]              o_rom_addr,
  input  logic [DATA_WIDTH-1:0]              i_rom_data,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_note_data,
  output logic [NUM_CHANNELS-1:0]            o_new_note_valid,
  output logic [NUM_CHANNELS-1:0]            o_done,
  output logic [NUM_CHANNELS-1:0]            o_overrun,
  output logic [NUM_CHANNELS-1:0]            o_active
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] gnt_q, gnt_d, rr_q, rr_d, idx, g;
  logic found, discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] note_q, note_d;
  logic [NUM_CHANNELS-1:0] ld_hit, stb_q, stb_d, pending_q, pending_d, active_q, active_d, loop_q, loop_d;
  logic [NUM_CHANNELS-1:0] valid_q, valid_d, done_q, done_d, ovr_q, ovr_d;
  logic [ADDR_WIDTH-1:0] base_q [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] base_d [NUM_CHANNELS];
  logic [LEN_WIDTH-1:0]  len_q  [NUM_CHANNELS];
  logic [LEN_WIDTH-1:0]  len_d  [NUM_CHANNELS];
  logic [LEN_WIDTH-1:0]  pos_q  [NUM_CHANNELS];
  logic [LEN_WIDTH-1:0]  pos_d  [NUM_CHANNELS];

  assign o_rom_addr       = rom_addr_q;
  assign o_note_data      = note_q;
  assign o_new_note_valid = valid_q;
  assign o_done           = done_q;
  assign o_overrun        = ovr_q;
  assign o_active         = active_q;

  // Load decode and round-robin search for the first pending channel at or after the pointer
  always_comb begin
    ld_hit = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) ld_hit[c] = i_new_addr_valid && (i_new_chan == CH_W'(c));
    found = 1'b0;
    g     = rr_q;
    idx   = rr_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        g     = idx;
      end
      idx = (idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : idx + CH_W'(1);
    end
  end

  // Fetch FSM, pattern advance, then loads and registered strobes (a load always overrides)
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    discard_d  = discard_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    valid_d    = '0;
    done_d     = '0;
    ovr_d      = '0;
    stb_d      = i_note_stb & ~ld_hit;
    pending_d  = pending_q;
    active_d   = active_q;
    loop_d     = loop_q;
    base_d     = base_q;
    len_d      = len_q;
    pos_d      = pos_q;
    if (state_q == S_IDLE) begin
      if (found) begin
        rom_addr_d   = base_q[g] + ADDR_WIDTH'(pos_q[g]);
        pending_d[g] = 1'b0;
        gnt_d        = g;
        rr_d         = (g == CH_W'(NUM_CHANNELS - 1)) ? '0 : g + CH_W'(1);
        discard_d    = ld_hit[g];
        state_d      = S_WAIT;
      end
    end else begin
      state_d = S_IDLE;
      if (!discard_q && !ld_hit[gnt_q]) begin
        note_d[gnt_q*DATA_WIDTH +: DATA_WIDTH] = i_rom_data;
        valid_d[gnt_q] = 1'b1;
        if (pos_q[gnt_q] + LEN_WIDTH'(1) == len_q[gnt_q]) begin
          pos_d[gnt_q] = '0;
          if (!loop_q[gnt_q]) begin
            active_d[gnt_q] = 1'b0;
            done_d[gnt_q]   = 1'b1;
          end
        end else pos_d[gnt_q] = pos_q[gnt_q] + LEN_WIDTH'(1);
      end
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ld_hit[c]) begin
        base_d[c]    = i_new_addr;
        len_d[c]     = i_new_pattern_len;
        loop_d[c]    = i_new_loop;
        pos_d[c]     = '0;
        pending_d[c] = 1'b0;
        active_d[c]  = |i_new_pattern_len;
      end else if (stb_q[c] && active_d[c]) begin
        if (pending_q[c]) ovr_d[c] = 1'b1;
        else pending_d[c] = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      discard_q  <= 1'b0;
      rom_addr_q <= '0;
      note_q     <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      ovr_q      <= '0;
      stb_q      <= '0;
      pending_q  <= '0;
      active_q   <= '0;
      loop_q     <= '0;
      base_q     <= '{default: '0};
      len_q      <= '{default: '0};
      pos_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      discard_q  <= discard_d;
      rom_addr_q <= rom_addr_d;
      note_q     <= note_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      stb_q      <= stb_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      loop_q     <= loop_d;
      base_q     <= base_d;
      len_q      <= len_d;
      pos_q      <= pos_d;
    end
  end
endmodule

// File: tb/tb_note_sequencer_mc.sv
// tb_note_sequencer_mc: scenario and randomized checks of note_sequencer_mc against a behavioural model
module tb_note_sequencer_mc;
  localparam int N = 4, AW = 5, DW = 16, LW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] stb = '0;
  logic nav = 1'b0, nloop = 1'b0;
  logic [1:0] nchan = '0;
  logic [AW-1:0] naddr = '0;
  logic [LW-1:0] nlen = '0;
  logic [AW-1:0] o_rom_addr;
  logic [DW-1:0] rom_data;
  logic [N*DW-1:0] o_note_data;
  logic [N-1:0] o_valid, o_done, o_ovr, o_act;
  logic [DW-1:0] rom [32];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[o_rom_addr];

  note_sequencer_mc #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_note_stb(stb), .i_new_addr_valid(nav), .i_new_chan(nchan),
    .i_new_addr(naddr), .i_new_pattern_len(nlen), .i_new_loop(nloop), .o_rom_addr(o_rom_addr),
    .i_rom_data(rom_data), .o_note_data(o_note_data), .o_new_note_valid(o_valid), .o_done(o_done),
    .o_overrun(o_ovr), .o_active(o_act)
  );

  // Behavioural model: per-channel pattern config, one outstanding fetch, strobes seen one cycle late
  int m_base[N], m_len[N], m_pos[N], m_ch, m_addr, m_rr, m_st, m_c;
  bit m_loop[N], m_act[N], m_pend[N], m_dstb[N], m_old[N], m_hit[N], m_busy, m_disc;
  logic [N*DW-1:0] e_note;
  logic [N-1:0] e_valid, e_done, e_ovr, e_act;
  logic [AW-1:0] e_addr;

  always @(posedge clk) begin
    e_valid = '0;
    e_done  = '0;
    e_ovr   = '0;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_base[c] = 0; m_len[c] = 0; m_pos[c] = 0;
        m_loop[c] = 0; m_act[c] = 0; m_pend[c] = 0; m_dstb[c] = 0;
      end
      m_busy = 0; m_disc = 0; m_rr = 0; m_ch = 0; m_addr = 0;
      e_note = '0; e_addr = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        m_hit[c] = nav && (int'(nchan) == c);
        m_old[c] = m_pend[c];
      end
      if (m_busy) begin
        m_busy = 0;
        if (!m_disc && !m_hit[m_ch]) begin
          e_note[m_ch*DW +: DW] = rom[5'(m_addr)];
          e_valid[m_ch] = 1'b1;
          if (m_pos[m_ch] + 1 == m_len[m_ch]) begin
            m_pos[m_ch] = 0;
            if (!m_loop[m_ch]) begin
              m_act[m_ch] = 0;
              e_done[m_ch] = 1'b1;
            end
          end else m_pos[m_ch] = m_pos[m_ch] + 1;
        end
      end else begin
        m_st = m_rr;
        for (int k = 0; k < N; k++) begin
          m_c = (m_st + k) % N;
          if (!m_busy && m_old[m_c]) begin
            m_busy = 1; m_ch = m_c;
            m_addr = (m_base[m_c] + m_pos[m_c]) % 32;
            e_addr = AW'(m_addr);
            m_pend[m_c] = 0;
            m_rr = (m_c + 1) % N;
            m_disc = m_hit[m_c];
          end
        end
      end
      for (int c = 0; c < N; c++) begin
        if (m_hit[c]) begin
          m_base[c] = int'(naddr); m_len[c] = int'(nlen); m_loop[c] = nloop;
          m_pos[c] = 0; m_pend[c] = 0; m_act[c] = (nlen != 0);
        end else if (m_dstb[c] && m_act[c]) begin
          if (m_old[c]) e_ovr[c] = 1'b1;
          else m_pend[c] = 1;
        end
      end
      for (int c = 0; c < N; c++) m_dstb[c] = stb[c] && !m_hit[c];
    end
    for (int c = 0; c < N; c++) e_act[c] = m_act[c];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input int ch, input int base, input int len, input bit lp);
    nav = 1'b1; nchan = 2'(ch); naddr = AW'(base); nlen = LW'(len); nloop = lp;
    tick();
    nav = 1'b0;
  endtask

  task automatic do_stb(input logic [N-1:0] m);
    stb = m;
    tick();
    stb = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (o_valid !== '0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (o_note_data !== '0) begin errors++; $display("FAIL reset_note got=%h want=0", o_note_data); end
    checks++; if (o_act !== '0 || o_done !== '0 || o_ovr !== '0) begin errors++; $display("FAIL reset_flags act=%b done=%b ovr=%b want=0", o_act, o_done, o_ovr); end
    checks++; if (o_rom_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", o_rom_addr); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] want [4];
    int lat;
    rom[3] = 16'hA1A1; rom[4] = 16'hB2B2; rom[5] = 16'hC3C3;
    want[0] = 16'hA1A1; want[1] = 16'hB2B2; want[2] = 16'hC3C3; want[3] = 16'hA1A1;
    do_load(0, 3, 3, 1);
    tick();
    for (int s = 0; s < 4; s++) begin
      do_stb(4'b0001);
      lat = 0;
      while (o_valid[0] !== 1'b1 && lat < 12) begin tick(); lat++; end
      checks++; if (lat != 3) begin errors++; $display("FAIL single_latency s=%0d got=%0d want=3", s, lat); end
      checks++; if (o_note_data[DW-1:0] !== want[s]) begin errors++; $display("FAIL single_note s=%0d got=%h want=%h", s, o_note_data[DW-1:0], want[s]); end
      tick(); tick();
    end
  endtask

  task automatic test_oneshot();
    int nv, nd, ndv;
    logic [DW-1:0] got;
    do_load(1, 10, 2, 0);
    checks++; if (o_act[1] !== 1'b1) begin errors++; $display("FAIL oneshot_active_on got=%b want=1", o_act[1]); end
    for (int s = 0; s < 3; s++) begin
      do_stb(4'b0010);
      nv = 0; nd = 0; ndv = 0; got = '0;
      for (int t = 0; t < 8; t++) begin
        tick();
        if (o_valid[1] === 1'b1) begin nv++; got = o_note_data[DW +: DW]; end
        if (o_done[1] === 1'b1) nd++;
        if (o_done[1] === 1'b1 && o_valid[1] === 1'b1) ndv++;
      end
      checks++; if (nv != (s < 2 ? 1 : 0)) begin errors++; $display("FAIL oneshot_valids s=%0d got=%0d want=%0d", s, nv, s < 2 ? 1 : 0); end
      if (s < 2) begin
        checks++; if (got !== rom[10 + s]) begin errors++; $display("FAIL oneshot_note s=%0d got=%h want=%h", s, got, rom[10 + s]); end
      end
      checks++; if (nd != (s == 1 ? 1 : 0) || ndv != nd) begin errors++; $display("FAIL oneshot_done s=%0d got=%0d with_valid=%0d want=%0d", s, nd, ndv, s == 1 ? 1 : 0); end
    end
    checks++; if (o_act[1] !== 1'b0) begin errors++; $display("FAIL oneshot_active_off got=%b want=0", o_act[1]); end
  endtask

  task automatic test_contention();
    int n, ord[4], at[4];
    do_reset();
    for (int c = 0; c < N; c++) do_load(c, 8 * c, 4, 1);
    tick();
    do_stb(4'hF);
    n = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      for (int c = 0; c < N; c++) if (o_valid[c] === 1'b1 && n < 4) begin
        ord[n] = c; at[n] = t; n++;
        checks++; if (o_note_data[c*DW +: DW] !== rom[8 * c]) begin errors++; $display("FAIL contention_note ch=%0d got=%h want=%h", c, o_note_data[c*DW +: DW], rom[8 * c]); end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL contention_count got=%0d want=4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ord[k] != k || at[k] != 3 + 2 * k) begin errors++; $display("FAIL contention_order k=%0d got ch=%0d at=%0d want ch=%0d at=%0d", k, ord[k], at[k], k, 3 + 2 * k); end
    end
  endtask

  task automatic test_fairness();
    int n, ord[2], at[2], lat;
    logic [AW-1:0] a3, want_a;
    do_reset();
    do_load(1, 0, 1, 1);
    do_load(0, 5, 2, 1);
    do_load(3, 30, 4, 1);
    tick();
    do_stb(4'b0010);
    repeat (6) tick();
    do_stb(4'b1001);
    n = 0; a3 = '0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      for (int c = 0; c < N; c++) if (o_valid[c] === 1'b1 && n < 2) begin
        ord[n] = c; at[n] = t; n++;
        if (c == 3) a3 = o_rom_addr;
      end
    end
    checks++; if (n != 2 || ord[0] != 3 || ord[1] != 0 || at[0] != 3 || at[1] != 5) begin errors++; $display("FAIL fair_order got n=%0d %0d@%0d %0d@%0d want 3@3 0@5", n, ord[0], at[0], ord[1], at[1]); end
    checks++; if (a3 !== 5'd30) begin errors++; $display("FAIL fair_addr k=0 got=%0d want=30", a3); end
    for (int k = 1; k < 4; k++) begin
      want_a = AW'(30 + k);
      do_stb(4'b1000);
      lat = 0;
      while (o_valid[3] !== 1'b1 && lat < 10) begin tick(); lat++; end
      checks++; if (lat != 3 || o_rom_addr !== want_a) begin errors++; $display("FAIL fair_addr k=%0d got=%0d lat=%0d want=%0d lat=3", k, o_rom_addr, lat, want_a); end
      checks++; if (o_note_data[3*DW +: DW] !== rom[want_a]) begin errors++; $display("FAIL fair_note k=%0d got=%h want=%h", k, o_note_data[3*DW +: DW], rom[want_a]); end
      tick();
    end
  endtask

  task automatic test_overrun();
    int nv, no;
    do_load(2, 7, 3, 1);
    tick();
    stb = 4'b0100;
    tick();
    tick();
    stb = '0;
    nv = 0; no = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (o_valid[2] === 1'b1) nv++;
      if (o_ovr[2] === 1'b1) no++;
    end
    checks++; if (no != 1) begin errors++; $display("FAIL overrun_pulses got=%0d want=1", no); end
    checks++; if (nv != 1) begin errors++; $display("FAIL overrun_valids got=%0d want=1", nv); end
  endtask

  task automatic test_edge();
    int nv, lat;
    do_load(0, 2, 2, 1);
    tick();
    stb = 4'b0001;
    tick();
    stb = '0;
    tick();
    tick();
    do_load(0, 20, 3, 1);
    nv = (o_valid[0] === 1'b1) ? 1 : 0;
    repeat (6) begin tick(); if (o_valid[0] === 1'b1) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL edge_discard got=%0d valids want=0", nv); end
    do_stb(4'b0001);
    lat = 0;
    while (o_valid[0] !== 1'b1 && lat < 10) begin tick(); lat++; end
    checks++; if (lat != 3 || o_rom_addr !== 5'd20) begin errors++; $display("FAIL edge_newbase got=%0d lat=%0d want=20 lat=3", o_rom_addr, lat); end
    checks++; if (o_note_data[DW-1:0] !== rom[20]) begin errors++; $display("FAIL edge_newnote got=%h want=%h", o_note_data[DW-1:0], rom[20]); end
    tick();
    do_load(2, 9, 0, 0);
    checks++; if (o_act[2] !== 1'b0) begin errors++; $display("FAIL edge_len0 got=%b want=0", o_act[2]); end
    do_stb(4'b0100);
    nv = 0;
    repeat (8) begin tick(); if (o_valid[2] === 1'b1) nv++; end
    checks++; if (nv != 0) begin errors++; $display("FAIL edge_len0_stb got=%0d valids want=0", nv); end
    stb = 4'b0001;
    tick();
    stb = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_valid !== '0 || o_note_data !== '0 || o_done !== '0 || o_ovr !== '0 || o_act !== '0 || o_rom_addr !== '0) begin
      errors++; $display("FAIL edge_rst_wait valid=%b note=%h done=%b ovr=%b act=%b addr=%0d want all 0", o_valid, o_note_data, o_done, o_ovr, o_act, o_rom_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      nav   = ($urandom_range(0, 11) == 0);
      nchan = 2'($urandom_range(0, 3));
      naddr = AW'($urandom);
      nlen  = LW'($urandom_range(0, 6));
      nloop = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < N; c++) stb[c] = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, o_valid, e_valid); end
      checks++; if (o_done !== e_done) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", i, o_done, e_done); end
      checks++; if (o_ovr !== e_ovr) begin errors++; $display("FAIL rnd_overrun cyc=%0d got=%b want=%b", i, o_ovr, e_ovr); end
      checks++; if (o_act !== e_act) begin errors++; $display("FAIL rnd_active cyc=%0d got=%b want=%b", i, o_act, e_act); end
      checks++; if (o_rom_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%0d want=%0d", i, o_rom_addr, e_addr); end
      checks++; if (o_note_data !== e_note) begin errors++; $display("FAIL rnd_note cyc=%0d got=%h want=%h", i, o_note_data, e_note); end
    end
    rst = 1'b0; nav = 1'b0; stb = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
    test_reset();
    test_single();
    test_oneshot();
    test_contention();
    test_fairness();
    test_overrun();
    test_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
